sample_collector: RTL and testbench

Bus-master stage directly downstream of the per-pin controllers. While running, it polls each pin controller's sample counter and sample register over the shared pin-controller bus. Each new sample is packed with its pin index and count, then pushed into an internal FIFO. The host drains the FIFO through the collector's own slave window on the host bus.

---
 rtl/sample_collector_pkg.sv | 38 +++
 rtl/sync_fifo.sv | 59 +++++
 rtl/sample_collector.sv | 160 ++++++++++++++++
 tb/tb_sample_collector.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_collector_pkg.sv
// Shared constants, state encoding and entry packing for the
// sample collector.
package sample_collector_pkg;

   localparam logic [7:0] REG_CTRL      = 8'd0;
   localparam logic [7:0] REG_FIFO_DATA = 8'd1;
   localparam logic [7:0] REG_STATUS    = 8'd2;
   localparam logic [7:0] REG_CLR       = 8'd3;

   localparam logic [7:0] PIN_SAMPLE_REG = 8'd7;
   localparam logic [7:0] PIN_SAMPLE_CNT = 8'd8;

   typedef enum logic [4:0] {
      S_IDLE   = 5'b00001,
      S_RD_CNT = 5'b00010,
      S_RD_SMP = 5'b00100,
      S_PUSH   = 5'b01000,
      S_NEXT   = 5'b10000
   } state_e;

   localparam int ENTRY_IDX_LSB = 12;
   localparam int ENTRY_CNT_LSB = 1;
   localparam int ENTRY_BIT_POS = 0;

   function automatic logic [15:0] pack_entry(
      input logic [3:0]  idx,
      input logic [10:0] cnt,
      input logic        smp
   );
      logic [15:0] e;
      e = '0;
      e[ENTRY_IDX_LSB +: 4]  = idx;
      e[ENTRY_CNT_LSB +: 11] = cnt;
      e[ENTRY_BIT_POS]       = smp;
      return e;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop & (count_q != '0);
      do_push  = push & ((count_q != (AW+1)'(DEPTH)) | do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop) count_d = count_q + 1'b1;
      if (do_pop && !do_push) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/sample_collector.sv
// Polls pin controllers for new samples and queues them in a FIFO
// that the host drains through a small slave register window.
module sample_collector
   import sample_collector_pkg::*;
#(
   parameter int         NUM_PINS   = 8,
   parameter int         FIFO_DEPTH = 16,
   parameter logic [7:0] POSITION   = 8'hF0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [18:0] addr,
   input  logic        data_wr,
   input  logic        data_rd,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   output logic [18:0] m_addr,
   output logic        m_enable,
   output logic        m_rd,
   input  logic [15:0] m_data,
   output logic        fifo_nempty
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_e      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [15:0] cur_cnt_q, cur_cnt_d;
   logic        cur_bit_q, cur_bit_d;
   logic        run_q, run_d;
   logic        ovf_q, ovf_d;
   logic        rd_q;
   logic        nempty_q, nempty_d;
   logic [18:0] m_addr_q;
   logic [15:0] last_cnt_q [16];
   logic [15:0] last_cnt_d [16];

   logic          sel;
   logic [7:0]    off;
   logic          push, pop;
   logic [15:0]   fifo_dout;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          unused_din;

   assign unused_din = ^data_in[15:1];
   assign sel = enable & (addr[18:8] == 11'(POSITION));
   assign off = addr[7:0];
   // pop only on the rising edge of a read so a held strobe pops once
   assign pop = sel & data_rd & ~rd_q & (off == REG_FIFO_DATA) & ~fifo_empty;

   always_comb begin
      run_d = run_q;
      ovf_d = ovf_q;
      if (sel && data_wr && off == REG_CTRL) run_d = data_in[0];
      if (sel && data_wr && off == REG_CLR)  ovf_d = 1'b0;
      if (state_q == S_PUSH && fifo_full && !pop) ovf_d = 1'b1;
   end

   always_comb begin
      data_out = '0;
      if (sel && data_rd) begin
         case (off)
            REG_CTRL:      data_out = {15'b0, run_q};
            REG_FIFO_DATA: data_out = fifo_empty ? '0 : fifo_dout;
            REG_STATUS:    data_out = {ovf_q, fifo_full, 6'b0, 8'(fifo_count)};
            default:       data_out = '0;
         endcase
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cur_cnt_d  = cur_cnt_q;
      cur_bit_d  = cur_bit_q;
      last_cnt_d = last_cnt_q;
      push       = 1'b0;
      m_enable   = 1'b0;
      m_rd       = 1'b0;
      m_addr     = m_addr_q;
      unique case (state_q)
         S_IDLE: begin
            idx_d = '0;
            if (run_q) state_d = S_RD_CNT;
         end
         S_RD_CNT: begin
            m_enable  = 1'b1;
            m_rd      = 1'b1;
            m_addr    = 19'({idx_q, PIN_SAMPLE_CNT});
            cur_cnt_d = m_data;
            state_d   = (m_data == last_cnt_q[idx_q]) ? S_NEXT : S_RD_SMP;
         end
         S_RD_SMP: begin
            m_enable  = 1'b1;
            m_rd      = 1'b1;
            m_addr    = 19'({idx_q, PIN_SAMPLE_REG});
            cur_bit_d = m_data[0];
            state_d   = S_PUSH;
         end
         S_PUSH: begin
            push              = 1'b1;
            last_cnt_d[idx_q] = cur_cnt_q;
            state_d           = S_NEXT;
         end
         S_NEXT: begin
            idx_d   = (idx_q == 4'(NUM_PINS - 1)) ? '0 : idx_q + 1'b1;
            state_d = run_q ? S_RD_CNT : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign nempty_d = ~fifo_empty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         cur_cnt_q <= '0;
         cur_bit_q <= 1'b0;
         run_q     <= 1'b0;
         ovf_q     <= 1'b0;
         rd_q      <= 1'b0;
         nempty_q  <= 1'b0;
         m_addr_q  <= '0;
         for (int i = 0; i < 16; i++) last_cnt_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cur_cnt_q  <= cur_cnt_d;
         cur_bit_q  <= cur_bit_d;
         run_q      <= run_d;
         ovf_q      <= ovf_d;
         rd_q       <= data_rd;
         nempty_q   <= nempty_d;
         m_addr_q   <= m_addr;
         last_cnt_q <= last_cnt_d;
      end
   end

   sync_fifo #(
      .WIDTH(16),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk  (clk),
      .reset(reset),
      .push (push),
      .pop  (pop),
      .din  (pack_entry(idx_q, cur_cnt_q[10:0], cur_bit_q)),
      .dout (fifo_dout),
      .full (fifo_full),
      .empty(fifo_empty),
      .count(fifo_count)
   );

   assign fifo_nempty = nempty_q;

endmodule

// File: tb/tb_sample_collector.sv
// Directed bench for sample_collector with a behavioural model of
// the pin-controller bus.
module tb_sample_collector;

   localparam logic [10:0] POS = 11'h0F0;
   localparam logic [7:0]  R_CTRL = 8'd0;
   localparam logic [7:0]  R_FIFO = 8'd1;
   localparam logic [7:0]  R_STAT = 8'd2;
   localparam logic [7:0]  R_CLR  = 8'd3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic [18:0] addr = '0;
   logic        data_wr = 1'b0;
   logic        data_rd = 1'b0;
   logic [15:0] data_in = '0;
   logic [15:0] data_out;
   logic [18:0] m_addr;
   logic        m_enable;
   logic        m_rd;
   logic [15:0] m_data;
   logic        fifo_nempty;

   logic [15:0] cnt [16];
   logic        bits [16];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sample_collector dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .addr       (addr),
      .data_wr    (data_wr),
      .data_rd    (data_rd),
      .data_in    (data_in),
      .data_out   (data_out),
      .m_addr     (m_addr),
      .m_enable   (m_enable),
      .m_rd       (m_rd),
      .m_data     (m_data),
      .fifo_nempty(fifo_nempty)
   );

   always_comb begin
      m_data = '0;
      if (m_enable && m_rd) begin
         if (m_addr[7:0] == 8'd8)
            m_data = cnt[m_addr[11:8]];
         else if (m_addr[7:0] == 8'd7)
            m_data = {15'b0, bits[m_addr[11:8]]};
      end
   end

   task automatic do_reset();
      reset = 1'b0;
      enable = 1'b0;
      data_wr = 1'b0;
      data_rd = 1'b0;
      addr = '0;
      data_in = '0;
      for (int i = 0; i < 16; i++) begin
         cnt[i] = '0;
         bits[i] = 1'b0;
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic host_read(input logic [7:0] off, output logic [15:0] d);
      @(negedge clk);
      enable = 1'b1;
      addr = {POS, off};
      data_rd = 1'b1;
      #1 d = data_out;
      @(negedge clk);
      data_rd = 1'b0;
      enable = 1'b0;
   endtask

   task automatic host_write(input logic [7:0] off, input logic [15:0] v);
      @(negedge clk);
      enable = 1'b1;
      addr = {POS, off};
      data_wr = 1'b1;
      data_in = v;
      @(negedge clk);
      enable = 1'b0;
      data_wr = 1'b0;
      data_in = '0;
   endtask

   task automatic test_reset();
      logic [15:0] d;
      int seen;
      do_reset();
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (m_rd) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL reset_m_rd: got %0d strobes, want 0", seen);
      end
      checks++;
      if (data_out !== 16'h0) begin
         errors++;
         $display("FAIL reset_data_out: got %h want 0000", data_out);
      end
      checks++;
      if (m_addr !== 19'h0) begin
         errors++;
         $display("FAIL reset_m_addr: got %h want 00000", m_addr);
      end
      host_read(R_STAT, d);
      checks++;
      if (d !== 16'h0000) begin
         errors++;
         $display("FAIL reset_status: got %h want 0000", d);
      end
      checks++;
      if (fifo_nempty !== 1'b0) begin
         errors++;
         $display("FAIL reset_nempty: got %b want 0", fifo_nempty);
      end
      host_read(R_CTRL, d);
      checks++;
      if (d !== 16'h0000) begin
         errors++;
         $display("FAIL reset_ctrl: got %h want 0000", d);
      end
      @(negedge clk);
      enable = 1'b1;
      addr = {11'h0F1, R_STAT};
      data_rd = 1'b1;
      #1;
      checks++;
      if (data_out !== 16'h0) begin
         errors++;
         $display("FAIL unselected_read: got %h want 0000", data_out);
      end
      @(negedge clk);
      enable = 1'b0;
      data_rd = 1'b0;
   endtask

   task automatic test_single_sample();
      logic [15:0] d;
      host_write(R_CTRL, 16'h0001);
      @(negedge clk);
      cnt[3] = 16'd5;
      bits[3] = 1'b1;
      repeat (40) @(negedge clk);
      host_read(R_STAT, d);
      checks++;
      if (d !== 16'h0001) begin
         errors++;
         $display("FAIL single_status: got %h want 0001", d);
      end
      checks++;
      if (fifo_nempty !== 1'b1) begin
         errors++;
         $display("FAIL single_nempty: got %b want 1", fifo_nempty);
      end
      host_read(R_FIFO, d);
      checks++;
      if (d !== 16'h300B) begin
         errors++;
         $display("FAIL single_entry: got %h want 300b", d);
      end
      host_read(R_STAT, d);
      checks++;
      if (d !== 16'h0000) begin
         errors++;
         $display("FAIL single_status_after: got %h want 0000", d);
      end
      @(negedge clk);
      checks++;
      if (fifo_nempty !== 1'b0) begin
         errors++;
         $display("FAIL single_nempty_after: got %b want 0", fifo_nempty);
      end
   endtask

   task automatic test_held_read();
      logic [15:0] d;
      @(negedge clk);
      cnt[1] = 16'd1;
      bits[1] = 1'b0;
      repeat (40) @(negedge clk);
      cnt[2] = 16'd7;
      bits[2] = 1'b1;
      repeat (40) @(negedge clk);
      host_read(R_STAT, d);
      checks++;
      if (d !== 16'h0002) begin
         errors++;
         $display("FAIL held_status_pre: got %h want 0002", d);
      end
      @(negedge clk);
      enable = 1'b1;
      addr = {POS, R_FIFO};
      data_rd = 1'b1;
      #1;
      checks++;
      if (data_out !== 16'h1002) begin
         errors++;
         $display("FAIL held_first: got %h want 1002", data_out);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (data_out !== 16'h200F) begin
         errors++;
         $display("FAIL held_head: got %h want 200f", data_out);
      end
      data_rd = 1'b0;
      enable = 1'b0;
      host_read(R_STAT, d);
      checks++;
      if (d !== 16'h0001) begin
         errors++;
         $display("FAIL held_status: got %h want 0001", d);
      end
      host_read(R_FIFO, d);
      checks++;
      if (d !== 16'h200F) begin
         errors++;
         $display("FAIL held_second: got %h want 200f", d);
      end
      host_read(R_FIFO, d);
      checks++;
      if (d !== 16'h0000) begin
         errors++;
         $display("FAIL empty_read: got %h want 0000", d);
      end
      host_read(R_STAT, d);
      checks++;
      if (d !== 16'h0000) begin
         errors++;
         $display("FAIL empty_no_pop: got %h want 0000", d);
      end
   endtask

   task automatic test_overflow();
      logic [15:0] d;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (m_rd && m_addr[7:0] == 8'd8)
            cnt[m_addr[11:8]] = cnt[m_addr[11:8]] + 16'd1;
      end
      host_write(R_CTRL, 16'h0000);
      repeat (10) @(negedge clk);
      host_read(R_STAT, d);
      checks++;
      if (d !== 16'hC010) begin
         errors++;
         $display("FAIL ovf_status: got %h want c010", d);
      end
      host_write(R_CLR, 16'h1234);
      host_read(R_STAT, d);
      checks++;
      if (d !== 16'h4010) begin
         errors++;
         $display("FAIL ovf_clr: got %h want 4010", d);
      end
      checks++;
      if (fifo_nempty !== 1'b1) begin
         errors++;
         $display("FAIL ovf_nempty: got %b want 1", fifo_nempty);
      end
      for (int i = 0; i < 16; i++) host_read(R_FIFO, d);
      host_read(R_STAT, d);
      checks++;
      if (d !== 16'h0000) begin
         errors++;
         $display("FAIL ovf_drain: got %h want 0000", d);
      end
   endtask

   task automatic test_mid_poll();
      logic [15:0] d;
      logic found;
      int seen;
      do_reset();
      host_write(R_CTRL, 16'h0001);
      cnt[5] = 16'd9;
      bits[5] = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge clk);
         if (m_rd && m_addr == 19'h00507) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL mid_wait_rd_smp: got timeout want pin5 sample read");
      end
      enable = 1'b1;
      addr = {POS, R_CTRL};
      data_wr = 1'b1;
      data_in = 16'h0000;
      @(negedge clk);
      enable = 1'b0;
      data_wr = 1'b0;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (m_rd) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL mid_idle: got %0d strobes want 0", seen);
      end
      checks++;
      if (m_addr !== 19'h00507) begin
         errors++;
         $display("FAIL mid_m_addr_hold: got %h want 00507", m_addr);
      end
      host_read(R_STAT, d);
      checks++;
      if (d !== 16'h0001) begin
         errors++;
         $display("FAIL mid_status: got %h want 0001", d);
      end
      host_read(R_FIFO, d);
      checks++;
      if (d !== 16'h5012) begin
         errors++;
         $display("FAIL mid_entry: got %h want 5012", d);
      end
   endtask

   task automatic test_async_reset();
      logic [15:0] d;
      logic found;
      logic [18:0] first_addr;
      do_reset();
      host_write(R_CTRL, 16'h0001);
      cnt[1] = 16'd3;
      bits[1] = 1'b1;
      repeat (40) @(negedge clk);
      checks++;
      if (fifo_nempty !== 1'b1) begin
         errors++;
         $display("FAIL ar_pre_nempty: got %b want 1", fifo_nempty);
      end
      cnt[0] = 16'd2;
      bits[0] = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(negedge clk);
         if (m_rd && m_addr == 19'h00007) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL ar_wait_rd_smp: got timeout want pin0 sample read");
      end
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      checks++;
      if (fifo_nempty !== 1'b0 || m_rd !== 1'b0 || m_addr !== 19'h0) begin
         errors++;
         $display("FAIL ar_immediate: got nempty=%b m_rd=%b m_addr=%h want 0 0 00000",
                  fifo_nempty, m_rd, m_addr);
      end
      #2 reset = 1'b1;
      host_read(R_STAT, d);
      checks++;
      if (d !== 16'h0000) begin
         errors++;
         $display("FAIL ar_status: got %h want 0000", d);
      end
      host_read(R_CTRL, d);
      checks++;
      if (d !== 16'h0000) begin
         errors++;
         $display("FAIL ar_run: got %h want 0000", d);
      end
      host_write(R_CTRL, 16'h0001);
      found = 1'b0;
      first_addr = '0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         if (m_rd) begin
            found = 1'b1;
            first_addr = m_addr;
         end
      end
      checks++;
      if (!found || first_addr !== 19'h00008) begin
         errors++;
         $display("FAIL ar_first_poll: got found=%b addr=%h want 1 00008",
                  found, first_addr);
      end
      repeat (40) @(negedge clk);
      host_read(R_STAT, d);
      checks++;
      if (d !== 16'h0002) begin
         errors++;
         $display("FAIL ar_resume_status: got %h want 0002", d);
      end
      host_read(R_FIFO, d);
      checks++;
      if (d !== 16'h0005) begin
         errors++;
         $display("FAIL ar_entry0: got %h want 0005", d);
      end
      host_read(R_FIFO, d);
      checks++;
      if (d !== 16'h1007) begin
         errors++;
         $display("FAIL ar_entry1: got %h want 1007", d);
      end
   endtask

   initial begin
      test_reset();
      test_single_sample();
      test_held_read();
      test_overflow();
      test_mid_poll();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
